// File: rtl/mul_seq_pkg.sv
// Shared constants for the iterative shift-add multiplier: operand mode
// encodings, FSM state encoding and the per-mode signedness decode.
package mul_seq_pkg;

  localparam logic [1:0] MUL_MODE_UU = 2'b00;  // unsigned x unsigned
  localparam logic [1:0] MUL_MODE_SS = 2'b01;  // signed x signed
  localparam logic [1:0] MUL_MODE_SU = 2'b10;  // signed(a) x unsigned(b)

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Encoding 11 falls through to unsigned on both operands.
  function automatic logic a_is_signed(input logic [1:0] mode);
    return (mode == MUL_MODE_SS) || (mode == MUL_MODE_SU);
  endfunction

  function automatic logic b_is_signed(input logic [1:0] mode);
    return mode == MUL_MODE_SS;
  endfunction

endpackage

// File: rtl/mul_pp_row.sv
// Combinational partial-product row: multiplicand times an R-bit digit,
// formed as a sum of shifted, AND-gated copies of the multiplicand.
module mul_pp_row #(
  parameter int unsigned N = 32,
  parameter int unsigned R = 2
) (
  input  logic [2*N-1:0] mcand_i,
  input  logic [R-1:0]   digit_i,
  output logic [2*N-1:0] pp_o
);

  // Sum mcand << i for every set digit bit (result wraps modulo 2^2N).
  always_comb begin
    pp_o = '0;
    for (int unsigned i = 0; i < R; i++) begin
      if (digit_i[i]) begin
        pp_o = pp_o + (mcand_i << i);
      end
    end
  end

endmodule

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier retiring R multiplier bits per clock.
// Operands are converted to magnitudes on accept; the sign is reapplied to
// the accumulated product on the final iteration.
// Optional: define MUL_SEQ_EARLY_TERM_EN to finish as soon as the remaining
// multiplier bits are all zero (same results, data-dependent latency).
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int unsigned N = 32,
  parameter int unsigned R = 2
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  input  logic [1:0]     mode_i,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [2*N-1:0] prod_o
);

  localparam int unsigned K    = N / R;
  localparam int unsigned CntW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(K - 1);

  if ((N % R) != 0) begin : gen_bad_params
    $error("mul_seq: N must be a multiple of R");
  end

  state_e          state_q, state_d;
  logic [2*N-1:0]  mcand_q, mcand_d;
  logic [N-1:0]    mplier_q, mplier_d;
  logic [2*N-1:0]  acc_q, acc_d;
  logic [2*N-1:0]  prod_q, prod_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            neg_q, neg_d;

  logic            a_neg, b_neg;
  logic [N-1:0]    a_mag, b_mag;
  logic [2*N-1:0]  pp;
  logic [2*N-1:0]  acc_next;
  logic [N-1:0]    mplier_shr;
  logic            finish;

  mul_pp_row #(
    .N(N),
    .R(R)
  ) u_pp_row (
    .mcand_i(mcand_q),
    .digit_i(mplier_q[R-1:0]),
    .pp_o   (pp)
  );

  // Operand magnitudes; the most negative value maps to 2^(N-1) unsigned.
  always_comb begin
    a_neg = a_is_signed(mode_i) && a_i[N-1];
    b_neg = b_is_signed(mode_i) && b_i[N-1];
    a_mag = a_neg ? -a_i : a_i;
    b_mag = b_neg ? -b_i : b_i;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;

    acc_next   = acc_q + pp;
    mplier_shr = mplier_q >> R;
`ifdef MUL_SEQ_EARLY_TERM_EN
    finish = (cnt_q == LastCnt) || (mplier_shr == '0);
`else
    finish = (cnt_q == LastCnt);
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i) begin
          mcand_d  = {{N{1'b0}}, a_mag};
          mplier_d = b_mag;
          acc_d    = '0;
          cnt_d    = '0;
          neg_d    = a_neg ^ b_neg;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << R;
        mplier_d = mplier_shr;
        cnt_d    = cnt_q + CntW'(1);
        if (finish) begin
          prod_d  = neg_q ? -acc_next : acc_next;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register with synchronous active-low clear.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
    end
  end

  assign ready_o = (state_q == ST_IDLE);
  assign valid_o = (state_q == ST_DONE);
  assign prod_o  = prod_q;

endmodule
